rgb_matrix_fx: RTL and testbench

//  Parametrised colour-effect engine for the RGB LED matrix PCB. It debounces the mode

---
 rtl/rgb_matrix_fx_if.sv | 14 +
 rtl/rgb_matrix_fx.sv | 212 +++++++++++++++++++++
 tb/tb_rgb_matrix_fx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_matrix_fx_if.sv
// Bundle of the matrix driver's user-facing signals: raw mode button in, effect
// number and per-LED R/G/B drive out.
interface rgb_matrix_fx_if #(
    parameter int NUM_LEDS = 25
);
    logic                button;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] R;
    logic [NUM_LEDS-1:0] G;
    logic [NUM_LEDS-1:0] B;

    modport master (output button, input mode, R, G, B);
    modport slave  (input button, output mode, R, G, B);
endinterface

// File: rtl/rgb_matrix_fx.sv
// Colour-effect engine for the RGB LED matrix: debounced mode button, OFF/HUE/
// BREATHE/CHASE effects and strict-compare PWM on every LED of each colour bus.
module rgb_matrix_fx #(
    parameter int NUM_LEDS    = 25,
    parameter int PWM_BITS    = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int STEP_CYCLES = 200000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    rgb_matrix_fx_if.slave bus
);
    localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W  = (NUM_LEDS    > 1) ? $clog2(NUM_LEDS)    : 1;

    localparam logic [PWM_BITS-1:0] MAXD      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]    DEB_ONE   = DEB_W'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_HUE     = 2'd1,
        M_BREATHE = 2'd2,
        M_CHASE   = 2'd3
    } mode_t;

    // Strict compare: duty 0 never lights, full-scale duty is dark for one slot.
    function automatic logic pwm_on(input logic [PWM_BITS-1:0] duty,
                                    input logic [PWM_BITS-1:0] cnt);
        return duty > cnt;
    endfunction

    mode_t               mode;
    logic                btn_s1;
    logic                btn_s2;
    logic                deb_level;
    logic [DEB_W-1:0]    deb_cnt;
    logic                press;
    logic [STEP_W-1:0]   presc;
    logic                tick;
    logic [1:0]          phase;
    logic [PWM_BITS-1:0] pos;
    logic [PWM_BITS-1:0] env;
    logic                env_down;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pcnt_p0;

    logic [PWM_BITS-1:0] hue_r;
    logic [PWM_BITS-1:0] hue_g;
    logic [PWM_BITS-1:0] hue_b;
    logic [PWM_BITS-1:0] duty_r [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_g [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_b [NUM_LEDS];

    logic [NUM_LEDS-1:0] r_p1;
    logic [NUM_LEDS-1:0] g_p1;
    logic [NUM_LEDS-1:0] b_p1;

    assign tick = (presc == STEP_LAST);

    // Stage p0: button conditioning, effect state, mode FSM and PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
            presc     <= '0;
            pcnt_p0   <= '0;
            mode      <= M_OFF;
            phase     <= 2'd0;
            pos       <= '0;
            env       <= '0;
            env_down  <= 1'b0;
            idx       <= '0;
        end else begin
            btn_s1 <= bus.button;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2 != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= btn_s2;
                    deb_cnt   <= '0;
                    press     <= ~btn_s2;
                end else begin
                    deb_cnt <= deb_cnt + DEB_ONE;
                end
            end else begin
                deb_cnt <= '0;
            end

            pcnt_p0 <= pcnt_p0 + DUTY_ONE;
            presc   <= tick ? '0 : presc + STEP_ONE;

            // The tick is consumed by the mode in force before any press lands.
            if (tick) begin
                if (mode == M_HUE || mode == M_CHASE) begin
                    if (pos == MAXD) begin
                        pos   <= '0;
                        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    end else begin
                        pos <= pos + DUTY_ONE;
                    end
                end
                if (mode == M_BREATHE) begin
                    if (!env_down) begin
                        env <= env + DUTY_ONE;
                        if (env == MAXD - DUTY_ONE) env_down <= 1'b1;
                    end else begin
                        env <= env - DUTY_ONE;
                        if (env == DUTY_ONE) env_down <= 1'b0;
                    end
                end
                if (mode == M_CHASE) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
                end
            end

            if (press) begin
                case (mode)
                    M_OFF: mode <= M_HUE;
                    M_HUE: begin
                        mode     <= M_BREATHE;
                        env      <= '0;
                        env_down <= 1'b0;
                    end
                    M_BREATHE: begin
                        mode <= M_CHASE;
                        idx  <= '0;
                    end
                    default: mode <= M_OFF;
                endcase
            end
        end
    end

    always_comb begin
        hue_r = '0;
        hue_g = '0;
        hue_b = '0;
        case (phase)
            2'd0: begin
                hue_r = MAXD - pos;
                hue_g = pos;
            end
            2'd1: begin
                hue_g = MAXD - pos;
                hue_b = pos;
            end
            default: begin
                hue_r = pos;
                hue_b = MAXD - pos;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_r[i] = '0;
            duty_g[i] = '0;
            duty_b[i] = '0;
            case (mode)
                M_HUE: begin
                    duty_r[i] = hue_r;
                    duty_g[i] = hue_g;
                    duty_b[i] = hue_b;
                end
                M_BREATHE: begin
                    duty_r[i] = env;
                    duty_g[i] = env;
                    duty_b[i] = env;
                end
                M_CHASE: begin
                    if (idx == IDX_W'(i)) begin
                        duty_r[i] = hue_r;
                        duty_g[i] = hue_g;
                        duty_b[i] = hue_b;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered PWM compare, one clock behind pcnt_p0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1 <= {NUM_LEDS{ACTIVE_LOW}};
            g_p1 <= {NUM_LEDS{ACTIVE_LOW}};
            b_p1 <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_p1[i] <= pwm_on(duty_r[i], pcnt_p0) ^ ACTIVE_LOW;
                g_p1[i] <= pwm_on(duty_g[i], pcnt_p0) ^ ACTIVE_LOW;
                b_p1[i] <= pwm_on(duty_b[i], pcnt_p0) ^ ACTIVE_LOW;
            end
        end
    end

    assign bus.mode = mode;
    assign bus.R    = r_p1;
    assign bus.G    = g_p1;
    assign bus.B    = b_p1;
endmodule

// File: tb/tb_rgb_matrix_fx.sv
// Scoreboard bench for rgb_matrix_fx: an active-high and an active-low instance share
// clock, reset and button; a cycle-level reference model predicts mode and R/G/B.
module tb_rgb_matrix_fx;
    localparam int N    = 4;
    localparam int PW   = 3;
    localparam int MAXV = 7;
    localparam int DEB  = 4;
    localparam int STEP = 4;

    typedef struct {
        logic [1:0]   mode;
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic [N-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;

    int checks = 0;
    int errors = 0;
    exp_t expq[$];

    rgb_matrix_fx_if #(.NUM_LEDS(N)) bus0 ();
    rgb_matrix_fx_if #(.NUM_LEDS(N)) bus1 ();
    assign bus0.button = btn;
    assign bus1.button = btn;

    rgb_matrix_fx #(.NUM_LEDS(N), .PWM_BITS(PW), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP),
                    .ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rgb_matrix_fx #(.NUM_LEDS(N), .PWM_BITS(PW), .DEB_CYCLES(DEB), .STEP_CYCLES(STEP),
                    .ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: hue as one index over 3*(MAX+1) wheel steps, breathe as an index
    // into a triangle of period 2*MAX, chase as idx mod N, timing from a cycle count.
    initial begin : model
        int n, h, bi, ci, md, nm, lvl, run, d1, d2, pq, pnext, pc, ph, pos, env;
        int hr, hg, hb, dr, dg, db;
        bit tick;
        exp_t e;
        n = 0; h = 0; bi = 0; ci = 0; md = 0; lvl = 1; run = 0; d1 = 1; d2 = 1; pq = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; h = 0; bi = 0; ci = 0; md = 0; lvl = 1; run = 0; d1 = 1; d2 = 1; pq = 0;
                e.mode = 2'd0; e.r = '0; e.g = '0; e.b = '0;
            end else begin
                pc  = n % (MAXV + 1);
                ph  = h / (MAXV + 1);
                pos = h % (MAXV + 1);
                env = (bi <= MAXV) ? bi : 2 * MAXV - bi;
                hr = 0; hg = 0; hb = 0;
                if (ph == 0) begin hr = MAXV - pos; hg = pos; end
                else if (ph == 1) begin hg = MAXV - pos; hb = pos; end
                else begin hr = pos; hb = MAXV - pos; end
                for (int i = 0; i < N; i++) begin
                    dr = 0; dg = 0; db = 0;
                    if (md == 1 || (md == 3 && i == ci)) begin dr = hr; dg = hg; db = hb; end
                    else if (md == 2) begin dr = env; dg = env; db = env; end
                    e.r[i] = (dr > pc);
                    e.g[i] = (dg > pc);
                    e.b[i] = (db > pc);
                end
                tick = ((n % STEP) == STEP - 1);
                nm = pq ? (md + 1) % 4 : md;
                if (tick) begin
                    if (md == 1 || md == 3) h = (h + 1) % (3 * (MAXV + 1));
                    if (md == 2) bi = (bi + 1) % (2 * MAXV);
                    if (md == 3) ci = (ci + 1) % N;
                end
                if (pq) begin
                    if (nm == 2) bi = 0;
                    if (nm == 3) ci = 0;
                end
                md = nm;
                pnext = 0;
                if (d2 != lvl) begin
                    run++;
                    if (run == DEB) begin
                        lvl = d2; run = 0; pnext = (d2 == 0);
                    end
                end else begin
                    run = 0;
                end
                pq = pnext;
                d2 = d1;
                d1 = int'(btn);
                n++;
                e.mode = 2'(md);
            end
            expq.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({bus0.mode, bus0.R, bus0.G, bus0.B} !== {e.mode, e.r, e.g, e.b}) begin
                    errors++;
                    $display("FAIL out_hi t=%0t got mode=%0d R=%h G=%h B=%h, expected mode=%0d R=%h G=%h B=%h",
                             $time, bus0.mode, bus0.R, bus0.G, bus0.B, e.mode, e.r, e.g, e.b);
                end
                checks++;
                if ({bus1.mode, bus1.R, bus1.G, bus1.B} !== {e.mode, ~e.r, ~e.g, ~e.b}) begin
                    errors++;
                    $display("FAIL out_lo t=%0t got mode=%0d R=%h G=%h B=%h, expected mode=%0d R=%h G=%h B=%h",
                             $time, bus1.mode, bus1.R, bus1.G, bus1.B, e.mode, ~e.r, ~e.g, ~e.b);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int len);
        btn = 1'b0;
        cyc(len);
        btn = 1'b1;
        cyc(DEB + 4);
    endtask

    task automatic glitch(input int len);
        btn = 1'b0;
        cyc(len);
        btn = 1'b1;
        cyc(DEB + 2);
    endtask

    initial begin : stim
        int act;
        int waited;
        cyc(4);
        rst = 1'b0;
        cyc(10);
        glitch(3);
        cyc(10);
        press(6);
        cyc(100);
        press(40);
        cyc(130);
        press(8);
        cyc(60);
        glitch($urandom_range(1, 3));
        cyc(20);
        press(7);
        btn = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        btn = 1'b1;
        cyc(12);
        press(6);
        cyc(40);
        for (int it = 0; it < 70; it++) begin
            act = int'($urandom_range(0, 11));
            if (act < 4) press(int'($urandom_range(5, 14)));
            else if (act < 6) glitch(int'($urandom_range(1, 4)));
            else if (act == 6) begin
                rst = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end else cyc(int'($urandom_range(10, 120)));
        end
        cyc(3);
        @(negedge clk);
        #1;
        waited = 0;
        while (expq.size() > 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain queue left=%0d required=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
